uart_rx: RTL and testbench

- 8N1 UART receiver for the CortexM0_SoC serial port. It is the receive-side counterpart of the SoC's TXD path and sits between the RXD pin and the APB/AHB UART register block.
- Samples RXD with 16x oversampling and validates the start bit. Assembles bytes LSB-first and checks the stop bit.
- Buffers received bytes in a small FIFO, drained through a valid/ready handshake.

---
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled RXD, start-bit glitch rejection,
// LSB-first assembly, stop-bit check, and a first-word fall-through receive FIFO.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          RXD,
  output logic [7:0]                    rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               rx_s_q, rx_s_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         sc_q, sc_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic tick, mid, last, stop_eval, full, push, pop;

  assign tick = (div_q == DIV_W'(DIV - 1));
  assign mid  = tick && (sc_q == 4'd7);
  assign last = tick && (sc_q == 4'd15);
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && rready;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      div_q       <= '0;
      sc_q        <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      div_q       <= div_d;
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s_q) state_d = START;
      START: begin
        if (mid && rx_s_q) state_d = IDLE;
        else if (last)     state_d = DATA;
      end
      DATA:    if (last && idx_q == 3'd7) state_d = STOP;
      STOP:    if (mid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing restarts on the falling edge so mid-bit samples land at sc==7.
  always_comb begin
    sync1_d = RXD;
    rx_s_d  = sync1_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    sc_d    = tick ? sc_q + 4'd1 : sc_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (state_q == IDLE && !rx_s_q) begin
      div_d = '0;
      sc_d  = '0;
    end
    if (state_q == START && last) idx_d = 3'd0;
    if (state_q == DATA) begin
      if (mid) shreg_d[idx_q] = rx_s_q;
      if (last && idx_q != 3'd7) idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    stop_eval   = (state_q == STOP) && mid;
    push        = stop_eval && rx_s_q && (!full || pop);
    frame_err_d = stop_eval && !rx_s_q;
    overrun_d   = stop_eval && rx_s_q && full && !pop;
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = shreg_q;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign rvalid    = (count_q != '0);
  assign rdata     = rvalid ? mem_q[rptr_q] : 8'd0;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes,
// a monitor pops and compares whenever a byte is handed over.
module tb_uart_rx;

  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD       = 10000;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_CYC    = 160;
  // Start-edge to rvalid: 3 cycles sync+detect, 9 bits, half of the stop bit.
  localparam int RVALID_LAT = 3 + 9 * BIT_CYC + 80;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          RXD = 1'b1;
  logic          rready = 1'b0;
  logic [7:0]    rdata;
  logic          rvalid;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int passCount = 0;
  int checkCount = 0;
  int cycleCnt = 0;
  int frameStartCycle = 0;
  int rvalidRiseCycle = -1;
  int frameErrPulses = 0, frameErrCycles = 0;
  int overrunPulses = 0, overrunCycles = 0;
  logic rvalidPrev = 1'b0, frameErrPrev = 1'b0, overrunPrev = 1'b0;
  logic [7:0] expQ [$];

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .RST(RST),
    .RXD(RXD),
    .rdata(rdata),
    .rvalid(rvalid),
    .rready(rready),
    .count(count),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
  endtask

  // Monitor: samples just after the falling edge, tracks pulses and pops the scoreboard.
  always @(negedge clk) begin
    #1;
    if (frame_err) frameErrCycles++;
    if (frame_err && !frameErrPrev) frameErrPulses++;
    if (overrun) overrunCycles++;
    if (overrun && !overrunPrev) overrunPulses++;
    if (rvalid && !rvalidPrev) rvalidRiseCycle = cycleCnt;
    frameErrPrev = frame_err;
    overrunPrev  = overrun;
    rvalidPrev   = rvalid;
    if (rvalid && rready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected byte: got 0x%0h, expected no byte", rdata);
      end else begin
        checkOutput("rdata", int'(rdata), int'(expQ.pop_front()));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit expectPush);
    if (expectPush) expQ.push_back(data);
    frameStartCycle = cycleCnt;
    RXD = 1'b0;
    waitCycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      RXD = data[i];
      waitCycles(BIT_CYC);
    end
    RXD = stopBit;
    waitCycles(BIT_CYC);
    RXD = 1'b1;
  endtask

  task automatic drainFifo(input string name);
    int budget;
    budget = 0;
    rready = 1'b1;
    while (count != '0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    rready = 1'b0;
    checkOutput({name, " drained count"}, int'(count), 0);
    checkOutput({name, " scoreboard empty"}, expQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fe0, fc0, ov0, oc0;
    waitCycles(3);
    checkOutput("reset rdata", int'(rdata), 0);
    checkOutput("reset rvalid", int'(rvalid), 0);
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset frame_err", int'(frame_err), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset busy", int'(busy), 0);
    RST = 1'b0;
    waitCycles(20);

    $display("[TB] single byte 0xA5");
    rvalidRiseCycle = -1;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    checkOutput("t1 rvalid latency", rvalidRiseCycle - frameStartCycle, RVALID_LAT);
    checkOutput("t1 count", int'(count), 1);
    checkOutput("t1 head", int'(rdata), 'hA5);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    waitCycles(1);
    checkOutput("t1 rvalid after pop", int'(rvalid), 0);
    checkOutput("t1 count after pop", int'(count), 0);
    checkOutput("t1 frame_err pulses", frameErrPulses, 0);
    checkOutput("t1 overrun pulses", overrunPulses, 0);
    waitCycles(50);

    $display("[TB] start glitch then 0x3C");
    RXD = 1'b0;
    waitCycles(20);
    checkOutput("t2 busy in glitch", int'(busy), 1);
    waitCycles(20);
    RXD = 1'b1;
    waitCycles(100);
    checkOutput("t2 busy after glitch", int'(busy), 0);
    checkOutput("t2 count after glitch", int'(count), 0);
    checkOutput("t2 frame_err pulses", frameErrPulses, 0);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    drainFifo("t2");
    waitCycles(50);

    $display("[TB] framing error then 0x12");
    fe0 = frameErrPulses; fc0 = frameErrCycles;
    applyStimulus(8'h55, 1'b0, 1'b0);
    waitCycles(200);
    checkOutput("t3 frame_err pulses", frameErrPulses - fe0, 1);
    checkOutput("t3 frame_err width", frameErrCycles - fc0, 1);
    checkOutput("t3 count", int'(count), 0);
    checkOutput("t3 busy", int'(busy), 0);
    applyStimulus(8'h12, 1'b1, 1'b1);
    drainFifo("t3");
    waitCycles(50);

    $display("[TB] overrun on fifth byte");
    ov0 = overrunPulses; oc0 = overrunCycles;
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1, b <= 4);
    waitCycles(10);
    checkOutput("t4 count full", int'(count), 4);
    checkOutput("t4 rvalid", int'(rvalid), 1);
    checkOutput("t4 overrun pulses", overrunPulses - ov0, 1);
    checkOutput("t4 overrun width", overrunCycles - oc0, 1);
    drainFifo("t4");
    waitCycles(50);

    $display("[TB] push and pop on a full fifo");
    ov0 = overrunPulses;
    for (int b = 1; b <= 4; b++) applyStimulus(8'(b * 'h11), 1'b1, 1'b1);
    fork
      applyStimulus(8'h55, 1'b1, 1'b1);
      begin
        waitCycles(RVALID_LAT - 1);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
      end
    join
    waitCycles(10);
    checkOutput("t5 count", int'(count), 4);
    checkOutput("t5 overrun pulses", overrunPulses - ov0, 0);
    drainFifo("t5");
    waitCycles(50);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h66, 1'b1, 1'b1);
    applyStimulus(8'h77, 1'b1, 1'b1);
    checkOutput("t6 count before reset", int'(count), 2);
    RXD = 1'b0;
    waitCycles(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      RXD = (i == 0) ? 1'b1 : 1'b0;
      waitCycles(BIT_CYC);
    end
    RXD = 1'b1;
    waitCycles(80);
    checkOutput("t6 busy before reset", int'(busy), 1);
    RST = 1'b1;
    #1;
    checkOutput("t6 rvalid in reset", int'(rvalid), 0);
    checkOutput("t6 count in reset", int'(count), 0);
    checkOutput("t6 busy in reset", int'(busy), 0);
    expQ.delete();
    @(negedge clk);
    RST = 1'b0;
    waitCycles(300);
    checkOutput("t6 count after reset", int'(count), 0);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    checkOutput("t6 count after frame", int'(count), 1);
    drainFifo("t6");
    checkOutput("t6 busy at end", int'(busy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
